// File: rtl/pistorm_pkg.sv
// Shared definitions for the PiStorm 68000 bus target: FSM encoding,
// function-code constants and the 24-bit bus address type.
package pistorm_pkg;

  typedef logic [2:0]  state_t;
  typedef logic [23:0] addr24_t;

  localparam state_t ST_IDLE = 3'd0;
  localparam state_t ST_WAIT = 3'd1;
  localparam state_t ST_ACK  = 3'd2;
  localparam state_t ST_ERR  = 3'd3;
  localparam state_t ST_MISS = 3'd4;

  localparam logic [2:0] FC_INT_ACK = 3'd7;

endpackage

// File: rtl/m68k_target_ram.sv
// Word-wide synchronous RAM with per-byte write enables and a registered,
// explicitly enabled read port.
module m68k_target_ram #(
  parameter int unsigned ADDR_BITS = 8
) (
  input  logic                 clk,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic                 re,
  input  logic [1:0]           we,
  input  logic [15:0]          wdata,
  output logic [15:0]          rdata
);

  logic [15:0] mem [1 << ADDR_BITS];
  logic [15:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we[1]) mem[addr][15:8] <= wdata[15:8];
    if (we[0]) mem[addr][7:0]  <= wdata[7:0];
    if (re)    rdata_q         <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/m68k_bus_target.sv
// 68000 bus responder: window decode, DTACK/BERR termination, wait-state
// counter, read-data tristate and a count of completed claimed cycles.
module m68k_bus_target
  import pistorm_pkg::*;
#(
  parameter addr24_t     BASE_ADDR   = 24'hE80000,
  parameter int unsigned ADDR_BITS   = 8,
  parameter int unsigned WAIT_STATES = 0,
  parameter int unsigned RO_WORDS    = 16
) (
  input  logic        M68K_CLK,
  input  logic        M68K_RESET_n,
  input  logic [23:1] M68K_A,
  inout  wire  [15:0] M68K_D,
  input  logic [2:0]  M68K_FC,
  input  logic        M68K_AS_n,
  input  logic        M68K_UDS_n,
  input  logic        M68K_LDS_n,
  input  logic        M68K_RW,
  output logic        M68K_DTACK_n,
  output logic        M68K_BERR_n,
  output logic [15:0] HIT_COUNT
);

  state_t               state_q, state_d;
  logic [ADDR_BITS-1:0] off_q, off_d;
  logic                 rw_q, rw_d;
  logic [3:0]           wcnt_q, wcnt_d;
  logic                 dtack_n_q, dtack_n_d;
  logic                 berr_n_q, berr_n_d;
  logic                 drive_q, drive_d;
  logic [15:0]          hit_q, hit_d;

  logic [ADDR_BITS-1:0] a_off;
  logic                 hit, ro;
  logic                 ram_re;
  logic [1:0]           ram_we;
  logic [ADDR_BITS-1:0] ram_addr;
  logic [15:0]          rd_data;

  assign a_off = M68K_A[ADDR_BITS:1];
  assign hit   = (M68K_A[23:ADDR_BITS+1] == BASE_ADDR[23:ADDR_BITS+1]) &&
                 (M68K_FC != FC_INT_ACK);
  assign ro    = 32'(a_off) < RO_WORDS;

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    rw_d    = rw_q;
    wcnt_d  = wcnt_q;
    hit_d   = hit_q;
    ram_re  = 1'b0;
    ram_we  = 2'b00;
    case (state_q)
      ST_IDLE: begin
        if (!M68K_AS_n) begin
          off_d = a_off;
          rw_d  = M68K_RW;
          if (!hit) begin
            state_d = ST_MISS;
          end else if (!M68K_RW && ro) begin
            state_d = ST_ERR;
          end else if (WAIT_STATES == 0) begin
            state_d = ST_ACK;
            ram_re  = M68K_RW;
          end else begin
            state_d = ST_WAIT;
            wcnt_d  = 4'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        if (M68K_AS_n) begin
          state_d = ST_IDLE;
        end else if (wcnt_q == 4'd1) begin
          state_d = ST_ACK;
          ram_re  = rw_q;
        end else begin
          wcnt_d = wcnt_q - 4'd1;
        end
      end
      ST_ACK: begin
        if (M68K_AS_n) begin
          state_d = ST_IDLE;
          hit_d   = hit_q + 16'd1;
        end else if (!rw_q) begin
          ram_we = {~M68K_UDS_n, ~M68K_LDS_n};
        end
      end
      ST_ERR, ST_MISS: begin
        if (M68K_AS_n) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe and drive flops follow the next state so they switch on the same edge.
  assign dtack_n_d = (state_d != ST_ACK);
  assign berr_n_d  = (state_d != ST_ERR);
  assign drive_d   = (state_d == ST_ACK) && rw_d;

  always_ff @(posedge M68K_CLK) begin
    if (!M68K_RESET_n) begin
      state_q   <= ST_IDLE;
      off_q     <= '0;
      rw_q      <= 1'b1;
      wcnt_q    <= 4'd0;
      dtack_n_q <= 1'b1;
      berr_n_q  <= 1'b1;
      drive_q   <= 1'b0;
      hit_q     <= 16'd0;
    end else begin
      state_q   <= state_d;
      off_q     <= off_d;
      rw_q      <= rw_d;
      wcnt_q    <= wcnt_d;
      dtack_n_q <= dtack_n_d;
      berr_n_q  <= berr_n_d;
      drive_q   <= drive_d;
      hit_q     <= hit_d;
    end
  end

  // A zero-wait read enters ACK straight from IDLE, so address the RAM live there.
  assign ram_addr = (state_q == ST_IDLE) ? a_off : off_q;

  m68k_target_ram #(
    .ADDR_BITS(ADDR_BITS)
  ) u_ram (
    .clk  (M68K_CLK),
    .addr (ram_addr),
    .re   (ram_re),
    .we   (ram_we),
    .wdata(M68K_D),
    .rdata(rd_data)
  );

  assign M68K_D       = drive_q ? rd_data : 16'hzzzz;
  assign M68K_DTACK_n = dtack_n_q;
  assign M68K_BERR_n  = berr_n_q;
  assign HIT_COUNT    = hit_q;

endmodule

// File: tb/tb_m68k_bus_target.sv
// Directed bench for m68k_bus_target: table of bus cycles on a zero-wait
// instance plus hand sequences for wait states, aborts and reset.
module tb_m68k_bus_target;

  localparam int MAXLAT = 8;
  localparam int K_NONE = 0, K_DTACK = 1, K_BERR = 2, K_BOTH = 3;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [22:0] a_bits;
  logic [2:0]  fc;
  logic        rw, uds_n, lds_n;
  logic        as0_n, as3_n;
  logic        drv0, drv3;
  logic [15:0] wd;
  wire  [15:0] d0, d3;
  logic        dt0, dt3, be0, be3;
  logic [15:0] hc0, hc3;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  assign d0 = drv0 ? wd : 16'hzzzz;
  assign d3 = drv3 ? wd : 16'hzzzz;
  pullup (d0);
  pullup (d3);

  m68k_bus_target #(.WAIT_STATES(0)) dut0 (
    .M68K_CLK(clk), .M68K_RESET_n(rst_n), .M68K_A(a_bits), .M68K_D(d0),
    .M68K_FC(fc), .M68K_AS_n(as0_n), .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n),
    .M68K_RW(rw), .M68K_DTACK_n(dt0), .M68K_BERR_n(be0), .HIT_COUNT(hc0)
  );

  m68k_bus_target #(.WAIT_STATES(3)) dut3 (
    .M68K_CLK(clk), .M68K_RESET_n(rst_n), .M68K_A(a_bits), .M68K_D(d3),
    .M68K_FC(fc), .M68K_AS_n(as3_n), .M68K_UDS_n(uds_n), .M68K_LDS_n(lds_n),
    .M68K_RW(rw), .M68K_DTACK_n(dt3), .M68K_BERR_n(be3), .HIT_COUNT(hc3)
  );

  typedef struct {
    logic [23:0] addr;
    logic [2:0]  fc;
    logic        rw;
    logic        uds_n;
    logic        lds_n;
    logic [15:0] wdata;
    int          exp_kind;
    int          exp_lat;
    logic [15:0] exp_rdata;
    logic [15:0] exp_count;
  } vec_t;

  vec_t vecs[$];

  function automatic logic get_dt(input int s); return (s == 0) ? dt0 : dt3; endfunction
  function automatic logic get_be(input int s); return (s == 0) ? be0 : be3; endfunction
  function automatic logic [15:0] get_d(input int s); return (s == 0) ? d0 : d3; endfunction
  function automatic logic [15:0] get_hc(input int s); return (s == 0) ? hc0 : hc3; endfunction

  task automatic set_as(input int s, input logic v);
    if (s == 0) as0_n = v; else as3_n = v;
  endtask

  task automatic set_drv(input int s, input logic v);
    if (s == 0) drv0 = v; else drv3 = v;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One complete bus cycle; AS_n is held one clock past the first response
  // so a write has a strobe-valid edge to capture on.
  task automatic bus_cycle(input int s, input logic [23:0] addr, input logic [2:0] f,
                           input logic r, input logic u_n, input logic l_n,
                           input logic [15:0] wdata, output int kind, output int lat,
                           output logic [15:0] rdata, output logic early_drive,
                           output logic rel_ok);
    @(negedge clk);
    a_bits = addr[23:1];
    fc     = f;
    rw     = r;
    uds_n  = u_n;
    lds_n  = l_n;
    wd     = wdata;
    set_drv(s, !r);
    set_as(s, 1'b0);
    kind = K_NONE;
    lat = 0;
    rdata = 16'h0000;
    early_drive = 1'b0;
    for (int i = 1; i <= MAXLAT; i++) begin
      @(negedge clk);
      if (!get_dt(s) || !get_be(s)) begin
        lat   = i;
        kind  = (!get_dt(s) && !get_be(s)) ? K_BOTH : (!get_dt(s) ? K_DTACK : K_BERR);
        rdata = get_d(s);
        break;
      end
      if (r && get_d(s) !== 16'hFFFF) early_drive = 1'b1;
    end
    @(negedge clk);
    if (!get_dt(s) && !get_be(s)) kind = K_BOTH;
    set_as(s, 1'b1);
    uds_n = 1'b1;
    lds_n = 1'b1;
    set_drv(s, 1'b0);
    @(negedge clk);
    rel_ok = get_dt(s) && get_be(s) && (get_d(s) === 16'hFFFF);
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int          kind, lat;
    logic [15:0] rdata;
    logic        early, rel_ok, seen;

    rst_n = 1'b0; a_bits = '0; fc = 3'd5; rw = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    as0_n = 1'b1; as3_n = 1'b1; drv0 = 1'b0; drv3 = 1'b0; wd = 16'h0000;

    //             addr       fc    rw    uds   lds   wdata     kind     lat rdata     count
    vecs.push_back('{24'hE80040, 3'd5, 1'b0, 1'b0, 1'b0, 16'hBEEF, K_DTACK, 1, 16'h0000, 16'd1});
    vecs.push_back('{24'hE80040, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, K_DTACK, 1, 16'hBEEF, 16'd2});
    vecs.push_back('{24'hE80030, 3'd5, 1'b0, 1'b0, 1'b0, 16'h5566, K_DTACK, 1, 16'h0000, 16'd3});
    vecs.push_back('{24'hE80030, 3'd5, 1'b0, 1'b1, 1'b0, 16'h12AB, K_DTACK, 1, 16'h0000, 16'd4});
    vecs.push_back('{24'hE80030, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, K_DTACK, 1, 16'h55AB, 16'd5});
    vecs.push_back('{24'hE80030, 3'd1, 1'b0, 1'b0, 1'b1, 16'h77CC, K_DTACK, 1, 16'h0000, 16'd6});
    vecs.push_back('{24'hE80030, 3'd1, 1'b1, 1'b0, 1'b0, 16'h0000, K_DTACK, 1, 16'h77AB, 16'd7});
    vecs.push_back('{24'hE80004, 3'd5, 1'b0, 1'b0, 1'b0, 16'hDEAD, K_BERR,  1, 16'h0000, 16'd7});
    vecs.push_back('{24'hE8001E, 3'd5, 1'b0, 1'b0, 1'b0, 16'hDEAD, K_BERR,  1, 16'h0000, 16'd7});
    vecs.push_back('{24'hE80020, 3'd5, 1'b0, 1'b0, 1'b0, 16'h1357, K_DTACK, 1, 16'h0000, 16'd8});
    vecs.push_back('{24'hE80020, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, K_DTACK, 1, 16'h1357, 16'd9});
    vecs.push_back('{24'hE00000, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, K_NONE,  0, 16'h0000, 16'd9});
    vecs.push_back('{24'hE80040, 3'd7, 1'b1, 1'b0, 1'b0, 16'h0000, K_NONE,  0, 16'h0000, 16'd9});
    vecs.push_back('{24'hE80200, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, K_NONE,  0, 16'h0000, 16'd9});
    vecs.push_back('{24'hE80040, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, K_DTACK, 1, 16'hBEEF, 16'd10});
    vecs.push_back('{24'hE801FE, 3'd5, 1'b0, 1'b0, 1'b0, 16'h2468, K_DTACK, 1, 16'h0000, 16'd11});
    vecs.push_back('{24'hE801FE, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, K_DTACK, 1, 16'h2468, 16'd12});

    repeat (3) @(negedge clk);
    chk("rst dtack0", dt0, 1'b1);
    chk("rst berr0", be0, 1'b1);
    chk("rst d0 hiz", d0, 16'hFFFF);
    chk("rst count0", hc0, 16'd0);
    chk("rst dtack3", dt3, 1'b1);
    chk("rst count3", hc3, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) begin
      bus_cycle(0, vecs[i].addr, vecs[i].fc, vecs[i].rw, vecs[i].uds_n, vecs[i].lds_n,
                vecs[i].wdata, kind, lat, rdata, early, rel_ok);
      chk($sformatf("v%0d kind", i), kind, vecs[i].exp_kind);
      chk($sformatf("v%0d latency", i), lat, vecs[i].exp_lat);
      if (vecs[i].rw && vecs[i].exp_kind == K_DTACK)
        chk($sformatf("v%0d rdata", i), rdata, vecs[i].exp_rdata);
      if (vecs[i].rw) chk($sformatf("v%0d no early drive", i), early, 1'b0);
      chk($sformatf("v%0d release", i), rel_ok, 1'b1);
      chk($sformatf("v%0d count", i), hc0, vecs[i].exp_count);
    end

    // Three wait states: DTACK_n three clocks after the zero-wait latency.
    bus_cycle(1, 24'hE80040, 3'd5, 1'b0, 1'b0, 1'b0, 16'h0F0F, kind, lat, rdata, early, rel_ok);
    chk("ws3 write kind", kind, K_DTACK);
    chk("ws3 write latency", lat, 4);
    bus_cycle(1, 24'hE80040, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, kind, lat, rdata, early, rel_ok);
    chk("ws3 read latency", lat, 4);
    chk("ws3 read data", rdata, 16'h0F0F);
    chk("ws3 no early drive", early, 1'b0);
    chk("ws3 count", hc3, 16'd2);

    // AS_n withdrawn while still counting wait states.
    @(negedge clk);
    a_bits = 23'(24'hE80040 >> 1); fc = 3'd5; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0;
    as3_n = 1'b0;
    repeat (2) @(negedge clk);
    as3_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (!dt3 || !be3 || d3 !== 16'hFFFF) seen = 1'b1;
    end
    chk("ws3 abort no response", seen, 1'b0);
    chk("ws3 abort count", hc3, 16'd2);
    bus_cycle(1, 24'hE80040, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, kind, lat, rdata, early, rel_ok);
    chk("ws3 after abort latency", lat, 4);
    chk("ws3 after abort data", rdata, 16'h0F0F);
    chk("ws3 after abort count", hc3, 16'd3);

    // Reset asserted while a read is being acknowledged.
    @(negedge clk);
    a_bits = 23'(24'hE80040 >> 1); fc = 3'd5; rw = 1'b1; uds_n = 1'b0; lds_n = 1'b0;
    as0_n = 1'b0;
    @(negedge clk);
    chk("rst-in-ack pre dtack", dt0, 1'b0);
    chk("rst-in-ack pre data", d0, 16'hBEEF);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst-in-ack dtack", dt0, 1'b1);
    chk("rst-in-ack hiz", d0, 16'hFFFF);
    chk("rst-in-ack count", hc0, 16'd0);
    rst_n = 1'b1; as0_n = 1'b1; uds_n = 1'b1; lds_n = 1'b1;
    @(negedge clk);
    bus_cycle(0, 24'hE80040, 3'd5, 1'b1, 1'b0, 1'b0, 16'h0000, kind, lat, rdata, early, rel_ok);
    chk("post-rst kind", kind, K_DTACK);
    chk("post-rst latency", lat, 1);
    chk("post-rst data", rdata, 16'hBEEF);
    chk("post-rst release", rel_ok, 1'b1);
    chk("post-rst count", hc0, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
